// File: rtl/alu_seq_ctrl.sv
// Sequencer for a registered ALU datapath: loads A and B, fires the F/FR capture
// strobe after a programmable wait, and returns the result on a valid/ready channel.
module alu_seq_ctrl #(
  parameter int DW        = 32,
  parameter int EXEC_WAIT = 1,
  parameter int CNT_W     = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [3:0]       req_op,
  input  logic [DW-1:0]    req_a,
  input  logic [DW-1:0]    req_b,
  input  logic             req_keep_a,
  input  logic             req_keep_b,
  output logic             ld_a,
  output logic             ld_b,
  output logic             ld_f,
  output logic [3:0]       alu_op,
  output logic [DW-1:0]    data_a,
  output logic [DW-1:0]    data_b,
  input  logic [DW-1:0]    f_in,
  input  logic [3:0]       fr_in,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [DW-1:0]    rsp_f,
  output logic [3:0]       rsp_fr,
  output logic             busy,
  output logic [CNT_W-1:0] op_count,
  output logic [2:0]       dbg_state
);

  // Handshakes: a transfer happens on a rising edge where valid and ready are both
  // high; the sender holds its payload stable until that edge, ready never waits on valid.

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_LOAD_A  = 3'd1,
    S_LOAD_B  = 3'd2,
    S_EXEC    = 3'd3,
    S_CAPTURE = 3'd4,
    S_RESP    = 3'd5
  } state_t;

  localparam logic [3:0] WAIT_LAST = 4'(EXEC_WAIT - 1);

  state_t            state_q, state_d;
  logic [3:0]        wait_q, wait_d;
  logic              a_vld_q, b_vld_q, kb_q;
  logic [3:0]        op_q;
  logic [DW-1:0]     a_q, b_q;
  logic              ld_a_q, ld_b_q, ld_f_q;
  logic              rsp_valid_q;
  logic [DW-1:0]     rsp_f_q;
  logic [3:0]        rsp_fr_q;
  logic [CNT_W-1:0]  cnt_q;
  logic              ka, kb;

  // A keep only counts once the register has been loaded since reset.
  assign ka = req_keep_a & a_vld_q;
  assign kb = req_keep_b & b_vld_q;

  always_comb begin
    state_d = state_q;
    wait_d  = '0;
    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          if (!ka)      state_d = S_LOAD_A;
          else if (!kb) state_d = S_LOAD_B;
          else          state_d = S_EXEC;
        end
      end
      S_LOAD_A:  state_d = kb_q ? S_EXEC : S_LOAD_B;
      S_LOAD_B:  state_d = S_EXEC;
      S_EXEC: begin
        if (wait_q == WAIT_LAST) state_d = S_CAPTURE;
        else                     wait_d  = wait_q + 4'd1;
      end
      S_CAPTURE: state_d = S_RESP;
      S_RESP:    if (rsp_ready) state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      wait_q      <= '0;
      a_vld_q     <= 1'b0;
      b_vld_q     <= 1'b0;
      kb_q        <= 1'b0;
      op_q        <= '0;
      a_q         <= '0;
      b_q         <= '0;
      ld_a_q      <= 1'b0;
      ld_b_q      <= 1'b0;
      ld_f_q      <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_f_q     <= '0;
      rsp_fr_q    <= '0;
      cnt_q       <= '0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      // Strobes are registered from the next state so each lines up with its state.
      ld_a_q  <= (state_d == S_LOAD_A);
      ld_b_q  <= (state_d == S_LOAD_B);
      ld_f_q  <= (state_d == S_EXEC) && (wait_d == WAIT_LAST);
      case (state_q)
        S_IDLE: begin
          if (req_valid) begin
            op_q <= req_op;
            a_q  <= req_a;
            b_q  <= req_b;
            kb_q <= kb;
          end
        end
        S_LOAD_A: a_vld_q <= 1'b1;
        S_LOAD_B: b_vld_q <= 1'b1;
        S_CAPTURE: begin
          rsp_f_q     <= f_in;
          rsp_fr_q    <= fr_in;
          rsp_valid_q <= 1'b1;
        end
        S_RESP: begin
          if (rsp_ready) begin
            rsp_valid_q <= 1'b0;
            cnt_q       <= cnt_q + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign req_ready = (state_q == S_IDLE);
  assign busy      = (state_q != S_IDLE);
  assign ld_a      = ld_a_q;
  assign ld_b      = ld_b_q;
  assign ld_f      = ld_f_q;
  assign alu_op    = op_q;
  assign data_a    = a_q;
  assign data_b    = b_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_f     = rsp_f_q;
  assign rsp_fr    = rsp_fr_q;
  assign op_count  = cnt_q;
  assign dbg_state = state_q;

endmodule
